// File: rtl/fb_ram_ctrl.sv
// Frame-buffer RAM controller: streams loader pixels into a single-port frame RAM
// and issues display reads inside the window. Optional macro: FB_LOAD_WRAP_EN.
module fb_ram_ctrl #(
  parameter int W        = 200,
  parameter int H        = 150,
  parameter int STARTROW = 0,
  parameter int STARTCOL = 0,
  parameter int AW       = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [11:0]   xpos,
  input  logic [11:0]   ypos,
  input  logic [7:0]    state,
  input  logic          wr_valid,
  input  logic [11:0]   wr_data,
  output logic          wr_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [11:0]   ram_wdata,
  output logic          load_done,
  output logic          rd_active
);

  localparam int NPIX = W * H;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t          r_fsm;
  logic [AW-1:0] r_wptr;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [11:0]   r_ram_wdata;
  logic          r_load_done;
  logic          r_rd_active;

  logic signed [31:0] w_x;
  logic signed [31:0] w_y;
  logic               w_in_win;
  logic               w_rd;
  logic               w_wr;
  logic               w_keep;
  logic               w_last;
  logic [AW-1:0]      w_rd_addr;

  assign w_x      = $signed({20'd0, xpos});
  assign w_y      = $signed({20'd0, ypos});
  assign w_in_win = (w_x >= STARTCOL) && (w_x < STARTCOL + W) &&
                    (w_y >= STARTROW) && (w_y < STARTROW + H);
  assign w_rd     = (state == 8'h03) && w_in_win;
  assign w_keep   = (state == 8'h02) || (state == 8'h03);
  assign w_last   = (r_wptr == AW'(NPIX - 1));
  // Linear address is truncated to AW bits and only ever reaches the outputs through a register.
  assign w_rd_addr = AW'((w_y - STARTROW) * W + (w_x - STARTCOL));

  // Reads win the port: the loader is simply not ready while a display read is pending.
  assign wr_ready = (r_fsm == S_LOAD) && !w_rd;
  assign w_wr     = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_wptr      <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_load_done <= 1'b0;
      r_rd_active <= 1'b0;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_rd_active <= 1'b0;
      if (w_rd) begin
        r_ram_en    <= 1'b1;
        r_ram_addr  <= w_rd_addr;
        r_rd_active <= 1'b1;
      end else if (w_wr) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= r_wptr;
        r_ram_wdata <= wr_data;
      end

      case (r_fsm)
        S_IDLE: begin
          r_load_done <= 1'b0;
          if (state == 8'h02) begin
            r_fsm  <= S_LOAD;
            r_wptr <= '0;
          end
        end
        S_LOAD: begin
`ifdef FB_LOAD_WRAP_EN
          r_load_done <= 1'b0;
`endif
          if (!w_keep) begin
            r_fsm       <= S_IDLE;
            r_load_done <= 1'b0;
          end else if (w_wr) begin
            if (w_last) begin
`ifdef FB_LOAD_WRAP_EN
              r_wptr      <= '0;
              r_load_done <= 1'b1;
`else
              r_fsm       <= S_DONE;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_wptr <= r_wptr + AW'(1);
            end
          end
        end
        S_DONE: begin
          if (!w_keep) begin
            r_fsm       <= S_IDLE;
            r_load_done <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= S_IDLE;
          r_load_done <= 1'b0;
        end
      endcase
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign load_done = r_load_done;
  assign rd_active = r_rd_active;

endmodule

// File: tb/tb_fb_ram_ctrl.sv
// Self-checking bench for fb_ram_ctrl: full load, mid-load reset, display read vectors,
// and load with an in-window scan position. Honours FB_LOAD_WRAP_EN when defined.
module tb_fb_ram_ctrl;
  localparam int W    = 200;
  localparam int H    = 150;
  localparam int AW   = 15;
  localparam int NPIX = W * H;
`ifdef FB_LOAD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int NLOAD = WRAP ? NPIX + 1 : NPIX;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   xpos, ypos;
  logic [7:0]    state;
  logic          wr_valid;
  logic [11:0]   wr_data;
  logic          wr_ready;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [11:0]   ram_wdata;
  logic          load_done, rd_active;

  fb_ram_ctrl #(.W(W), .H(H), .STARTROW(0), .STARTCOL(0), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .state(state),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .load_done(load_done), .rd_active(rd_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_idx = 0;
  int pix_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int i);
    return 12'(i * 7 + 3);
  endfunction

  // Scoreboard for every write command seen on the RAM port.
  always @(posedge clk) begin
    #1;
    if (ram_en === 1'b1 && ram_we === 1'b1) begin
      chk("wr_addr", 32'(ram_addr), 32'(exp_idx % NPIX));
      chk("wr_data", 32'(ram_wdata), 32'(pix(exp_idx)));
      chk("wr_done", 32'(load_done), 32'((exp_idx % NPIX) == NPIX - 1));
      chk("wr_vs_rd", 32'(rd_active), 32'd0);
      $display("write idx=%0d addr=%0d data=%0h done=%0b", exp_idx, ram_addr, ram_wdata, load_done);
      exp_idx++;
    end
  end

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = pix(pix_cnt);
      pix_cnt++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_en", 32'(ram_en), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_ready", 32'(wr_ready), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_rd", 32'(rd_active), 0);
  endtask

  typedef struct {
    logic [7:0]    st;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          en;
    logic [AW-1:0] addr;
    logic          rd;
    logic          done;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{8'h03, 12'd5,    12'd2,    1'b1, 15'd405,   1'b1, 1'b1};
    vt[1]  = '{8'h03, 12'd200,  12'd0,    1'b0, 15'd405,   1'b0, 1'b1};
    vt[2]  = '{8'h03, 12'd0,    12'd150,  1'b0, 15'd405,   1'b0, 1'b1};
    vt[3]  = '{8'h03, 12'd0,    12'd0,    1'b1, 15'd0,     1'b1, 1'b1};
    vt[4]  = '{8'h03, 12'd199,  12'd149,  1'b1, 15'd29999, 1'b1, 1'b1};
    vt[5]  = '{8'h03, 12'd4095, 12'd4095, 1'b0, 15'd29999, 1'b0, 1'b1};
    vt[6]  = '{8'h02, 12'd10,   12'd1,    1'b0, 15'd29999, 1'b0, 1'b1};
    vt[7]  = '{8'h03, 12'd10,   12'd1,    1'b1, 15'd210,   1'b1, 1'b1};
    vt[8]  = '{8'h03, 12'd199,  12'd0,    1'b1, 15'd199,   1'b1, 1'b1};
    vt[9]  = '{8'h03, 12'd0,    12'd149,  1'b1, 15'd29800, 1'b1, 1'b1};
    vt[10] = '{8'h01, 12'd5,    12'd2,    1'b0, 15'd29800, 1'b0, 1'b0};

    rst_n = 1'b0; state = 8'h02; xpos = 12'd4095; ypos = 12'd4095;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_load", 32'(wr_ready), 1);

    // Partial load, then reset mid-stream.
    push(100);
    chk("partial_count", 32'(exp_idx), 100);
    chk("partial_done", 32'(load_done), 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_idx = 0;
    pix_cnt = 0;

    // Full reload from address 0.
    push(NLOAD);
    chk("load_count", 32'(exp_idx), 32'(NLOAD));
    if (WRAP) begin
      chk("wrap_done_after", 32'(load_done), 0);
      chk("wrap_ready_after", 32'(wr_ready), 1);
    end else begin
      chk("done_after_load", 32'(load_done), 1);
      chk("ready_after_load", 32'(wr_ready), 0);
      wr_valid = 1'b1;
      @(posedge clk); #1;
      chk("no_write_in_done", 32'(ram_en), 0);
      chk("done_held", 32'(load_done), 1);
      @(negedge clk);
      wr_valid = 1'b0;
    end

    // Display read vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      state = vt[i].st; xpos = vt[i].x; ypos = vt[i].y;
      @(posedge clk); #1;
      $display("vec %0d st=%0h x=%0d y=%0d en=%0b we=%0b addr=%0d rd=%0b done=%0b",
               i, vt[i].st, vt[i].x, vt[i].y, ram_en, ram_we, ram_addr, rd_active, load_done);
      chk("vec_en", 32'(ram_en), 32'(vt[i].en));
      chk("vec_we", 32'(ram_we), 0);
      chk("vec_addr", 32'(ram_addr), 32'(vt[i].addr));
      chk("vec_rd", 32'(rd_active), 32'(vt[i].rd));
      chk("vec_done", 32'(load_done), 32'(vt[i].done && !WRAP));
    end

    // Load with the scan position inside the window: state 02 must not read.
    @(negedge clk);
    state = 8'h02; xpos = 12'd5; ypos = 12'd2;
    exp_idx = 0;
    pix_cnt = 0;
    @(posedge clk); #1;
    chk("inwin_ready", 32'(wr_ready), 1);
    chk("inwin_rd", 32'(rd_active), 0);
    push(5);
    chk("inwin_count", 32'(exp_idx), 5);
    chk("inwin_rd_after", 32'(rd_active), 0);
    chk("inwin_done", 32'(load_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_ram_ctrl.md
FB_RAM_CTRL -- requirements
Module: fb_ram_ctrl

Interface
REQ-001 SHALL have parameter W, default 200: image width in pixels.
REQ-002 SHALL have parameter H, default 150: image height in pixels.
REQ-003 SHALL have parameter STARTROW, default 0: first display row; parameter STARTCOL, default 0: first display column.
REQ-004 SHALL have parameter AW, default 15: RAM address width, sized so that 2^AW >= W*H.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports xpos, ypos, input, 12 each: current VGA scan position.
REQ-008 SHALL have port state, input, 8: system state; 8'h02 = load, 8'h03 = display, any other value = idle.
REQ-009 SHALL have ports wr_valid (in, 1), wr_data (in, 12), wr_ready (out, 1): loader pixel stream with valid/ready handshake.
REQ-010 SHALL have ports ram_en, ram_we (out, 1 each), ram_addr (out, AW), ram_wdata (out, 12): single-port frame RAM command.
REQ-011 SHALL have ports load_done (out, 1) and rd_active (out, 1): status outputs.

Function
REQ-012 SHALL define the display window as STARTCOL <= xpos < STARTCOL+W and STARTROW <= ypos < STARTROW+H.
REQ-013 SHALL implement FSM IDLE / LOAD / DONE: IDLE->LOAD when state becomes 8'h02; LOAD->DONE when pixel W*H-1 is accepted; any state->IDLE when state is neither 8'h02 nor 8'h03.
REQ-014 SHALL clear the write pointer to 0 on every IDLE->LOAD transition.
REQ-015 SHALL complete a write transfer on any cycle with wr_valid & wr_ready; on the next edge it SHALL drive ram_en=1, ram_we=1, ram_addr=write pointer, ram_wdata=wr_data, and SHALL increment the pointer.
REQ-016 SHALL drive wr_ready=1 only in LOAD, and only while the read condition in REQ-017 is false.
REQ-017 SHALL treat state==8'h03 with the scan position inside the window as a read, with priority over writes.
REQ-018 For each read, SHALL register ram_en=1, ram_we=0, ram_addr=(ypos-STARTROW)*W+(xpos-STARTCOL), with 1-cycle latency from xpos/ypos; rd_active SHALL be registered alongside it.
REQ-019 SHALL truncate address arithmetic to AW bits; the multiply SHALL NOT be combinationally exposed on outputs.
REQ-020 SHALL drive ram_en=0, ram_we=0 on cycles with neither a read nor a write; ram_addr and ram_wdata SHALL hold their previous values.
REQ-021 SHALL assert load_done=1 in DONE, and SHALL keep it through display (state 8'h03), until the FSM returns to IDLE.
REQ-022 SHALL never assert ram_we and a read in the same cycle.

Reset
REQ-023 While rst_n=0, SHALL hold: FSM=IDLE, write pointer=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, wr_ready=0, load_done=0, rd_active=0.
REQ-024 A reset asserted mid-load SHALL discard the partial load; a new load restarts at address 0.

Configuration
REQ-025 SHALL support macro FB_LOAD_WRAP_EN.
REQ-026 With FB_LOAD_WRAP_EN defined, SHALL wrap the write pointer from W*H-1 to 0 and remain in LOAD, with wr_ready still asserted; load_done SHALL pulse for one cycle on each wrap.
REQ-027 Without FB_LOAD_WRAP_EN, SHALL behave per REQ-013: DONE is entered after the last pixel, and wr_ready stays 0 until the next IDLE->LOAD transition.

Verification
REQ-028 SHALL cover this case: reset, state=02, 30000 consecutive valid pixels (W=200,H=150) -> writes to addr 0..29999; load_done=1 after the last pixel; wr_ready=0.
REQ-029 SHALL cover this case: state=03, xpos=5, ypos=2 -> one cycle later ram_en=1, ram_we=0, ram_addr=405, rd_active=1.
REQ-030 SHALL cover this case: state=03, xpos=200 or ypos=150 -> ram_en=0, rd_active=0.
REQ-031 SHALL cover this case: state=02 with an in-window position and state held at 02 -> writes proceed; the read path stays inactive because state!=03.
REQ-032 SHALL cover this case: rst_n pulled low after 100 pixels, then reload -> the first write after reload goes to addr 0 and load_done=0 until pixel 29999.
REQ-033 SHALL cover this case: FB_LOAD_WRAP_EN defined, 30001 pixels -> pixel 30000 is written to addr 0 and load_done pulses for exactly one cycle.
